// File: rtl/decoder_select_sequencer.sv
// decoder_select_sequencer
// Upstream driver for a 2-to-4 decoder with enable. A 2-bit target address
// is accepted over a 4-phase req/ack handshake and latched. en is then held
// high for max(hold,1) clocks with x1/x0 stable. All outputs are registered.
// Optional feature macro: SEQ_AUTOSCAN_EN (adds 'scan' input; idle-time
// self-running SELECTs that step through the addresses without ack).
module decoder_select_sequencer #(
    parameter int HOLD_W = 4
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              req,
    input  logic [1:0]        addr,
    input  logic [HOLD_W-1:0] hold,
`ifdef SEQ_AUTOSCAN_EN
    input  logic              scan,
`endif
    output logic              en,
    output logic              x1,
    output logic              x0,
    output logic              busy,
    output logic              ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] hold_eff;

    // A hold of zero still gives a one-cycle enable pulse
    assign hold_eff = (hold == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : hold;

`ifdef SEQ_AUTOSCAN_EN
    logic       auto_run;   // current SELECT was self-started, skips DONE
    logic [1:0] next_addr;

    assign next_addr = {x1, x0} + 2'd1;
`endif

    // Sequencer FSM; every output is a register so the decoder never sees glitches
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            cnt      <= '0;
            en       <= 1'b0;
            x1       <= 1'b0;
            x0       <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b0;
`ifdef SEQ_AUTOSCAN_EN
            auto_run <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        {x1, x0} <= addr;
                        cnt      <= hold_eff;
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SELECT;
`ifdef SEQ_AUTOSCAN_EN
                        auto_run <= 1'b0;
                    end else if (scan) begin
                        {x1, x0} <= next_addr;
                        cnt      <= hold_eff;
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        auto_run <= 1'b1;
                        state    <= SELECT;
`endif
                    end
                end
                SELECT: begin
                    // Inputs are ignored here; the latched address and count rule
                    cnt <= cnt - 1'b1;
                    if (cnt == {{(HOLD_W-1){1'b0}}, 1'b1}) begin
                        en <= 1'b0;
`ifdef SEQ_AUTOSCAN_EN
                        if (auto_run) begin
                            auto_run <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            ack   <= 1'b1;
                            state <= DONE;
                        end
`else
                        ack   <= 1'b1;
                        state <= DONE;
`endif
                    end
                end
                DONE: begin
                    // Wait for the requester's low phase before re-arming
                    if (!req) begin
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Bench for decoder_select_sequencer: a transaction-level model (remaining
// enable cycles + pending-ack flag) is checked against the DUT every cycle,
// plus directed scenarios with hand-computed pulse lengths and latencies.
module tb_decoder_select_sequencer;

    logic       clock;
    logic       reset_;
    logic       req;
    logic [1:0] addr;
    logic [3:0] hold;
`ifdef SEQ_AUTOSCAN_EN
    logic       scan;
`endif
    logic       en, x1, x0, busy, ack;

    decoder_select_sequencer #(.HOLD_W(4)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .req    (req),
        .addr   (addr),
        .hold   (hold),
`ifdef SEQ_AUTOSCAN_EN
        .scan   (scan),
`endif
        .en     (en),
        .x1     (x1),
        .x0     (x0),
        .busy   (busy),
        .ack    (ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Model: how many enable cycles remain, whether an ack is owed, latched address
    int         left   = 0;
    bit         m_ack  = 0;
    bit         m_auto = 0;
    logic [1:0] m_x    = 2'd0;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            left <= 0; m_ack <= 0; m_auto <= 0; m_x <= 2'd0;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                m_auto <= 0;
                if (!m_auto) m_ack <= 1;
            end
        end else if (m_ack) begin
            if (!req) m_ack <= 0;
        end else if (req) begin
            m_x  <= addr;
            left <= (hold == 0) ? 1 : int'(hold);
`ifdef SEQ_AUTOSCAN_EN
        end else if (scan) begin
            m_x    <= m_x + 2'd1;
            left   <= (hold == 0) ? 1 : int'(hold);
            m_auto <= 1;
`endif
        end
    end

    // Per-cycle comparison against the model plus the output invariants
    logic       prev_en = 1'b0;
    logic [1:0] prev_x  = 2'd0;
    always @(negedge clock) begin
        chk("m_en",   int'(en),   int'(left > 0));
        chk("m_ack",  int'(ack),  int'(m_ack));
        chk("m_busy", int'(busy), int'((left > 0) || m_ack));
        chk("m_x",    int'({x1, x0}), int'(m_x));
        chk("en_ack_excl", int'(en && ack), 0);
        if (prev_en && en) chk("x_stable_en", int'({x1, x0}), int'(prev_x));
        prev_en <= en;
        prev_x  <= {x1, x0};
    end

    // Caller is at a negedge with the DUT idle; returns at a negedge, idle again
    task automatic run_req(input logic [1:0] a, input int h, input int exp_len,
                           input bit perturb, input int linger, output int st);
        int n;
        int g;
        req = 1'b1; addr = a; hold = h[3:0];
        @(negedge clock);
        st = cyc; n = 0; g = 0;
        while (en && g < 64) begin
            n++; g++;
            if (perturb) begin addr = ~addr; hold = hold + 4'd5; end
            @(negedge clock);
        end
        chk("en_len", n, exp_len);
        chk("ack_after_en", int'(ack), 1);
        chk("x_latched", int'({x1, x0}), int'(a));
        repeat (linger) begin
            @(negedge clock);
            chk("ack_held", int'(ack), 1);
            chk("no_retrigger", int'(en), 0);
        end
        req = 1'b0;
        @(negedge clock);
        chk("ack_drop", int'(ack), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int s1, s2, g;
        reset_ = 1'b0; req = 1'b0; addr = 2'd0; hold = 4'd0;
`ifdef SEQ_AUTOSCAN_EN
        scan = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("rst_en", int'(en), 0);
        chk("rst_x",  int'({x1, x0}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        reset_ = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", int'(busy), 0);

        // Basic select: 3 enable cycles on line 10
        run_req(2'b10, 3, 3, 1'b0, 0, s1);
        // Zero hold behaves as one
        run_req(2'b01, 0, 1, 1'b0, 0, s1);
        // Inputs toggled during SELECT are ignored; req held in DONE 5 cycles
        run_req(2'b11, 4, 4, 1'b1, 5, s1);
        // Max hold then immediate re-request: turnaround 15+2
        run_req(2'b11, 15, 15, 1'b0, 0, s1);
        run_req(2'b00, 2, 2, 1'b0, 0, s2);
        chk("turnaround", s2 - s1, 17);

        // Async reset while en is high: drops before the next edge
        req = 1'b1; addr = 2'b01; hold = 4'd8;
        repeat (3) @(negedge clock);
        chk("pre_rst_en", int'(en), 1);
        #2 reset_ = 1'b0;
        #1;
        chk("async_en", int'(en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_x", int'({x1, x0}), 0);
        req = 1'b0;
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        chk("rerun_idle", int'(busy), 0);

`ifdef SEQ_AUTOSCAN_EN
        begin
            logic [1:0] got[$];
            logic [1:0] expv[4];
            expv[0] = 2'd1; expv[1] = 2'd2; expv[2] = 2'd3; expv[3] = 2'd0;
            scan = 1'b1; hold = 4'd1;
            g = 0;
            while (got.size() < 4 && g < 40) begin
                @(negedge clock);
                g++;
                chk("scan_no_ack", int'(ack), 0);
                if (en) got.push_back({x1, x0});
            end
            chk("scan_pulses", got.size(), 4);
            for (int i = 0; i < 4 && i < got.size(); i++)
                chk("scan_addr", int'(got[i]), int'(expv[i]));
            // Request arrives mid-scan: scan SELECT completes, then request served
            hold = 4'd3;
            g = 0;
            while (!en && g < 20) begin @(negedge clock); g++; end
            chk("scan_en_seen", int'(en), 1);
            req = 1'b1; addr = 2'b10;
            g = 0;
            while (!ack && g < 40) begin @(negedge clock); g++; end
            chk("scan_req_ack", int'(ack), 1);
            chk("scan_req_x", int'({x1, x0}), 2);
            scan = 1'b0; req = 1'b0;
            @(negedge clock);
            chk("scan_req_drop", int'(ack), 0);
        end
`endif

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decoder_select_sequencer.md
Name: decoder_select_sequencer

Overview:
Upstream driver for the 2-to-4 decoder with enable. It accepts a 2-bit target address through a 4-phase req/ack handshake and latches it. It then drives the decoder's x1/x0/en inputs so the selected output line is asserted for a programmable number of clock cycles. All outputs are registered, so the decoder sees glitch-free, stable selects.

Parameters:
HOLD_W, 4, width of the hold-length input and of the internal down-counter.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_  input  1  asynchronous, active-low reset
req  input  1  request; 4-phase handshake with ack
addr  input  2  target line {x1,x0}; sampled only when a request is accepted
hold  input  HOLD_W  number of cycles en stays high; sampled with addr; 0 is treated as 1
en  output  1  enable to the decoder
x1  output  1  address MSB to the decoder
x0  output  1  address LSB to the decoder
busy  output  1  high in every state except IDLE
ack  output  1  request complete; 4-phase acknowledge

Behaviour:
- Reset (reset_=0, asynchronous): state=IDLE, en=0, x1=0, x0=0, busy=0, ack=0, counter=0. Takes effect immediately, including mid-SELECT: en drops without waiting for a clock edge.
- Release of reset_ is sampled on the next rising edge; normal operation starts then.
- FSM states: IDLE, SELECT, DONE.
- IDLE:
  - en=0, ack=0, busy=0.
  - x1/x0 hold their last value (00 after reset).
  - On an edge with req=1: latch {x1,x0}<=addr, counter<=(hold==0 ? 1 : hold), go to SELECT.
- SELECT:
  - en=1, busy=1.
  - Each edge: counter<=counter-1.
  - On the edge where counter==1: go to DONE.
  - Result: en is high for exactly max(hold,1) cycles.
  - addr, hold and req changes are ignored in this state.
  - If req is deasserted early, the sequence still completes. ack is then raised in DONE and dropped on the following edge, because req is already 0.
- DONE:
  - en=0, ack=1, busy=1.
  - x1/x0 unchanged.
  - On an edge with req=0: ack<=0, go to IDLE.
  - While req stays 1, remain in DONE. No retrigger without a req low phase.
- Latency: req sampled at edge k → en=1 from edge k+1 through edge k+H (H=max(hold,1)) → ack=1 from edge k+1+H.
- Turnaround: minimum cycle between consecutive accepted requests is H+2 clocks.
- Invariants:
  - en=1 only in SELECT.
  - x1/x0 never change while en=1.
  - en and ack are never high in the same cycle.
- Width rules: hold is unsigned. hold=all-ones gives 2^HOLD_W−1 cycles. The counter never wraps below 1.

Optional Feature:
- Macro: SEQ_AUTOSCAN_EN.
- When defined:
  - Extra input port scan (1 bit).
  - In IDLE with req=0 and scan=1, the block runs a SELECT on its own, using the next address ({x1,x0}+1, wrapping 3→0) and the current hold. This autoscan SELECT does not raise ack and returns directly to IDLE.
  - req=1 in IDLE has priority over scan. An autoscan SELECT in progress is never preempted.
- When undefined: the scan port does not exist and behaviour is exactly as above.

Test Plan:
- Reset then idle: reset_=0 for 3 cycles, release → en=0, x1x0=00, busy=0, ack=0. Assert reset_=0 mid-SELECT → en=0 immediately, before the next edge.
- Basic select: addr=10, hold=3, req=1 at edge k → en=1 at edges k+1..k+3, x1x0=10 stable, ack=1 at k+4. Drop req → ack=0 and IDLE at the next edge.
- Zero hold: addr=01, hold=0 → en high exactly 1 cycle, then ack=1.
- Input changes ignored: during SELECT toggle addr 11→00 and hold → x1x0 and en duration unchanged. Keep req=1 in DONE for 5 cycles → ack held, no second en pulse.
- Max hold and back-to-back: hold=15, addr=11 → en high 15 cycles. Immediately re-request addr=00, hold=2 after the req low phase → turnaround of 17 clocks measured, x1x0 changes only while en=0.
- (SEQ_AUTOSCAN_EN) scan=1, req=0, hold=1, start x1x0=00 → en pulses with x1x0=01,10,11,00, ack stays 0 throughout. Assert req mid-scan → the current scan SELECT completes, then the requested addr is served with ack.
